// File: rtl/sysarr_pkg.sv
// Shared definitions for the systolic-array sequencer: run states, default
// geometry and derived word/vector widths.
package sysarr_pkg;

  localparam int DEF_N  = 31;
  localparam int DEF_NV = 4;
  localparam int WORD_W = DEF_N + 1;
  localparam int VEC_W  = WORD_W * DEF_NV;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sysarr_state_e;

endpackage

// File: rtl/sysarr_sequencer_if.sv
// Load/run handshake and array-facing outputs of the sequencer, bundled as one
// interface; the sequencer is the slave, the loader/controller the master.
interface sysarr_sequencer_if
  import sysarr_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int n     = DEF_NV,
  parameter int FLG_W = 7
);
  localparam int IDX_W = (n > 1) ? $clog2(n) : 1;
  localparam int VW    = (N + 1) * n;

  logic             ld_valid;
  logic             ld_ready;
  logic             ld_sel;
  logic [IDX_W-1:0] ld_idx;
  logic [VW-1:0]    ld_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [VW-1:0]    arr1_o;
  logic [VW-1:0]    arr2_o;
  logic [FLG_W-1:0] flg_o;

  modport master (
    output ld_valid, ld_sel, ld_idx, ld_data, start,
    input  ld_ready, busy, done, arr1_o, arr2_o, flg_o
  );

  modport slave (
    input  ld_valid, ld_sel, ld_idx, ld_data, start,
    output ld_ready, busy, done, arr1_o, arr2_o, flg_o
  );

endinterface

// File: rtl/sysarr_vecbuf.sv
// n-entry vector register file: one write port, one combinational read port,
// synchronous clear. Out-of-range indices write nothing and read zero.
module sysarr_vecbuf #(
  parameter int ENTRIES = 4,
  parameter int WIDTH   = 128,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [WIDTH-1:0] mem_d [ENTRIES];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_idx) < ENTRIES)) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = (int'(rd_idx) < ENTRIES) ? mem_q[rd_idx] : '0;

endmodule

// File: rtl/sysarr_sequencer.sv
// Steps the systolic array through n feed cycles and a zero-padded drain phase
// from two loadable vector banks; all outputs registered one cycle after state.
module sysarr_sequencer
  import sysarr_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int n     = DEF_NV,
  parameter int FLG_W = 7,
  parameter int STEPS = 20
) (
  input logic               clk,
  input logic               rst,
  sysarr_sequencer_if.slave bus
);

  localparam int WW    = N + 1;
  localparam int VW    = WW * n;
  localparam int IDX_W = (n > 1) ? $clog2(n) : 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_FEED  = FEED;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [FLG_W-1:0] K_FEED_LAST = FLG_W'(n - 1);
  localparam logic [FLG_W-1:0] K_LAST      = FLG_W'(STEPS - 1);
  localparam logic [VW-1:0]    VEC_ZERO    = {n{WW'(FP32_ZERO)}};

  logic [1:0]       state_q, state_d;
  logic [FLG_W-1:0] k_q, k_d;
  logic             ld_ready_q, ld_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [FLG_W-1:0] flg_q, flg_d;
  logic [VW-1:0]    arr1_q, arr1_d;
  logic [VW-1:0]    arr2_q, arr2_d;

  logic          wr_a, wr_b;
  logic [VW-1:0] rd_a, rd_b;

  // ld_ready_q mirrors state_q == IDLE, so it alone gates bank writes.
  assign wr_a = bus.ld_valid && ld_ready_q && !bus.ld_sel;
  assign wr_b = bus.ld_valid && ld_ready_q &&  bus.ld_sel;

  sysarr_vecbuf #(.ENTRIES(n), .WIDTH(VW), .IDX_W(IDX_W)) u_bank_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_a),
    .wr_idx  (bus.ld_idx),
    .wr_data (bus.ld_data),
    .rd_idx  (k_q[IDX_W-1:0]),
    .rd_data (rd_a)
  );

  sysarr_vecbuf #(.ENTRIES(n), .WIDTH(VW), .IDX_W(IDX_W)) u_bank_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_b),
    .wr_idx  (bus.ld_idx),
    .wr_data (bus.ld_data),
    .rd_idx  (k_q[IDX_W-1:0]),
    .rd_data (rd_b)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FEED;
          k_d     = '0;
        end
      end
      S_FEED: begin
        k_d = k_q + FLG_W'(1);
        if (k_q == K_FEED_LAST) begin
          state_d = (STEPS > n) ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        k_d = k_q + FLG_W'(1);
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs trail the state by one register stage, so a load committed on the
  // start edge is already in the bank when step 0 is read.
  always_comb begin
    ld_ready_d = (state_d == S_IDLE);
    busy_d     = (state_q == S_FEED) || (state_q == S_DRAIN);
    done_d     = (state_q == S_DONE);
    flg_d      = '0;
    arr1_d     = VEC_ZERO;
    arr2_d     = VEC_ZERO;
    case (state_q)
      S_FEED: begin
        flg_d  = k_q;
        arr1_d = rd_a;
        arr2_d = rd_b;
      end
      S_DRAIN: flg_d = k_q;
      S_DONE:  flg_d = K_LAST;
      default: flg_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      ld_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flg_q      <= '0;
      arr1_q     <= '0;
      arr2_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      flg_q      <= flg_d;
      arr1_q     <= arr1_d;
      arr2_q     <= arr2_d;
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.flg_o    = flg_q;
  assign bus.arr1_o   = arr1_q;
  assign bus.arr2_o   = arr2_q;

endmodule
